// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared length codes, FSM states and constants for the data-memory responder.
package dmem_responder_pkg;
  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [31:0] RDATA_ZERO = 32'h0;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, replicated store word and extended load result for one access.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  len,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);
  logic [15:0] rsh;
  always_comb begin
    rsh   = 16'(rword >> (len == LEN_HALF ? {addr_lo[1], 4'b0} : {addr_lo, 3'b0}));
    rdata = len == LEN_BYTE ? {{24{sgn & rsh[7]}}, rsh[7:0]} :
            len == LEN_HALF ? {{16{sgn & rsh[15]}}, rsh} :
            len == LEN_WORD ? rword : RDATA_ZERO;
    be    = len == LEN_BYTE ? 4'b0001 << addr_lo :
            len == LEN_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
            len == LEN_WORD ? 4'b1111 : 4'b0000;
    // Replicating the data puts it on every lane; the byte enable picks the real one.
    wword = len == LEN_BYTE ? {4{wdata[7:0]}} :
            len == LEN_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory slave; DMEM_ERROR_CHECK_EN enables misalign/range errors.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_length,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam bit ZERO_LAT = LATENCY == 0;
  localparam logic [3:0] CNT_LOAD = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic write_q, write_d, sgn_q, sgn_d;
  logic [1:0] len_q, len_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic accept, go_resp, err, we;
  logic cur_write, cur_sgn;
  logic [1:0] cur_len;
  logic [31:0] cur_addr, cur_wdata, wword, lane_rdata;
  logic [3:0] be;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [2**ADDR_WIDTH];
  // With zero latency the RAM is accessed on the accept edge, so the live request is used.
  always_comb begin
    accept    = state_q == IDLE && req_valid && req_ready_q;
    cur_write = state_q == IDLE ? req_write : write_q;
    cur_len   = state_q == IDLE ? req_length : len_q;
    cur_sgn   = state_q == IDLE ? req_signed : sgn_q;
    cur_addr  = state_q == IDLE ? req_address : addr_q;
    cur_wdata = state_q == IDLE ? req_wdata : wdata_q;
    idx       = cur_addr[ADDR_WIDTH+1:2];
    go_resp   = (accept && ZERO_LAT) || (state_q == WAIT && cnt_q == 4'd0);
    state_d   = go_resp ? RESP : accept ? WAIT : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    cnt_d     = accept ? CNT_LOAD : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
    write_d   = accept ? req_write : write_q;
    len_d     = accept ? req_length : len_q;
    sgn_d     = accept ? req_signed : sgn_q;
    addr_d    = accept ? req_address : addr_q;
    wdata_d   = accept ? req_wdata : wdata_q;
    we        = go_resp && cur_write && !err;
    rsp_rdata_d = go_resp ? ((cur_write || err) ? RDATA_ZERO : lane_rdata) : rsp_rdata_q;
    rsp_error_d = go_resp ? err : rsp_error_q;
  end
`ifdef DMEM_ERROR_CHECK_EN
  assign err = cur_len != LEN_NONE && (cur_addr[31:ADDR_WIDTH+2] != '0 ||
               (cur_len == LEN_HALF && cur_addr[0]) || (cur_len == LEN_WORD && cur_addr[1:0] != 2'b00));
`else
  logic unused_hi;
  assign unused_hi = ^cur_addr[31:ADDR_WIDTH+2];
  assign err = 1'b0;
`endif
  dmem_lane_align u_align (
    .len(cur_len), .sgn(cur_sgn), .addr_lo(cur_addr[1:0]), .wdata(cur_wdata),
    .rword(mem[idx]), .be(be), .wword(wword), .rdata(lane_rdata)
  );
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= RDATA_ZERO;
      rsp_error_q <= 1'b0;
      write_q     <= 1'b0;
      len_q       <= LEN_NONE;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      write_q     <= write_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end
  always_ff @(posedge SYS_clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory request interface, replacing the zero-latency combinational data memory with a handshaked, multi-cycle slave. It accepts one byte, halfword or word load/store request at a time, using the same length/signed encoding the datapath already drives. After a programmable wait it returns the aligned, extended read data or a store acknowledge, with an error flag. It sits between the core's load/store path and the on-chip data RAM, so that later multi-cycle or pipelined cores can stall on memory.

## Interface
- ADDR_WIDTH, 10: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: wait cycles between acceptance and response; legal range 0..15.
- SYS_clk  in  1  sole clock, rising edge.
- SYS_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_length  in  2  00 none, 01 byte, 10 half, 11 word.
- req_signed  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- req_address  in  32  byte address, little-endian.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores, errors and length 00.
- rsp_error  out  1  request was misaligned or out of range.

## Operation
- FSM states:
  - IDLE (req_ready=1).
  - WAIT (count LATENCY cycles).
  - RESP (rsp_valid=1).
- IDLE→WAIT on req_valid&req_ready when LATENCY>0. IDLE→RESP directly when LATENCY=0.
- WAIT→RESP when the 4-bit down-counter, loaded with LATENCY-1 at accept, reaches 0.
- RESP→IDLE on rsp_ready. RESP holds with all response outputs stable while rsp_ready=0.
- All request fields are registered at acceptance. Inputs are ignored outside IDLE.
- Word index = addr[ADDR_WIDTH+1:2].
- Out of range: addr[31:ADDR_WIDTH+2] != 0.
- Misaligned:
  - half with addr[0]=1;
  - word with addr[1:0] != 0.
- Stores:
  - byte writes lane addr[1:0];
  - half writes lanes {addr[1],0} and {addr[1],1};
  - word writes all four lanes.
  - Other lanes are untouched. Data comes from req_wdata[7:0], [15:0] or [31:0].
- Loads:
  - extract the addressed lane(s) and shift to bit 0;
  - extend per req_signed. Word loads ignore req_signed.
- Length 00 is a no-op: it completes normally with rdata 0, error 0 and no write.
- Errors: write suppressed, rdata 0, rsp_error=1.
- RAM contents are not initialised and not affected by reset.

## Timing
- Accept in cycle 0.
- RAM write commit and read sample both happen on the edge that enters RESP.
- rsp_valid rises in cycle 1+LATENCY.
- With rsp_ready held high, req_ready returns in cycle 2+LATENCY.
- Maximum throughput is one request per LATENCY+2 cycles.
- A load issued immediately after a store to the same address returns the new data.
- Reset, including mid-WAIT or mid-RESP:
  - state goes to IDLE immediately;
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0;
  - any pending store is dropped if not yet committed;
  - req_ready is 0 while SYS_reset is high and 1 on the first cycle after release.

## Configuration
- DMEM_ERROR_CHECK_EN defined: misalignment and out-of-range detection as above.
- DMEM_ERROR_CHECK_EN undefined:
  - rsp_error is tied 0;
  - alignment bits below the access size are forced to 0 (half ignores addr[0], word ignores addr[1:0]);
  - upper address bits are ignored, so accesses wrap modulo capacity.

## Structure
- Shared package holds:
  - length codes LEN_NONE/LEN_BYTE/LEN_HALF/LEN_WORD;
  - the FSM state enum (IDLE, WAIT, RESP);
  - the response-data-zero constant.
- Sub-module dmem_lane_align (combinational): from length, signed, addr[1:0], store data and the raw read word, it produces:
  - 4-bit byte enable;
  - shifted write word;
  - extended load result.
- The top holds the FSM, counter, request registers and RAM array.

## Test plan
- LATENCY=2:
  - store word 0xDEADBEEF @0x10, then load word @0x10 → rsp_rdata=0xDEADBEEF, rsp_error=0;
  - rsp_valid rises exactly 3 cycles after each accept.
- Then:
  - lb @0x13 signed → 0xFFFFFFDE;
  - lbu @0x13 → 0x000000DE;
  - lh @0x10 → 0xFFFFBEEF;
  - sb 0x5A @0x11, then lw @0x10 → 0xDEAD5AEF.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0 throughout; one cycle after rsp_ready=1, req_ready=1.
- Error build: word store 0x11111111 @0x12 → rsp_error=1; lw @0x10 still returns 0xDEAD5AEF. Load @0x0000_1000 with ADDR_WIDTH=10 → rsp_error=1, rdata=0.
- Reset mid-WAIT after accepting sw 0x12345678 @0x20 → after release lw @0x20 does not return 0x12345678; req_ready=1 on the first post-reset cycle.
- LATENCY=0 build: lw accepted in cycle N → rsp_valid in cycle N+1. Length 00 request → rdata 0, error 0, no memory change.
